ex_hazard_controller: RTL and testbench
=======================================

Name: ex_hazard_controller

Overview:
- Sequences the Execute stage of the 5-stage RISCV core.
- Tracks the destination register of every in-flight instruction in EX, MEM and WB.
- Produces the registered forward mux selects consumed by the Execute stage, and stalls/bubbles the front end on load-use hazards.
- Sequences multi-cycle front-end flushes when Execute redirects the PC.

Parameters:
- REG_ADDR_W, 5, width of register addresses
- FLUSH_DEPTH, 2, total bubbles inserted per PC redirect (1..7)
- CNT_W, 32, width of performance counters (optional feature only)

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- id_valid_ip  in  1  Decode holds a valid instruction this cycle
- id_rs1_addr_ip  in  REG_ADDR_W  source register 1 of Decode instruction
- id_rs2_addr_ip  in  REG_ADDR_W  source register 2
- id_rs1_used_ip  in  1  instruction reads rs1
- id_rs2_used_ip  in  1  instruction reads rs2
- id_rd_addr_ip  in  REG_ADDR_W  destination register
- id_rd_wen_ip  in  1  instruction writes rd
- id_is_load_ip  in  1  instruction is a load
- ex_flush_en_ip  in  1  Execute redirect (flush_en from Execute stage)
- fa_mux_op  out  forward_mux_code  operand A select for instruction entering/in EX
- fb_mux_op  out  forward_mux_code  operand B select
- stall_op  out  1  hold PC and IF/ID buffer
- bubble_op  out  1  load NOP into ID/EX buffer this cycle
- flush_op  out  1  squash IF/ID contents

Behaviour:
- Internal slots EX, MEM, WB each hold {valid, rd, wen, is_load}. They shift every clock: WB<=MEM, MEM<=EX, EX<=issued instruction, or invalid if bubble_op.
- Issue: the Decode instruction issues when id_valid_ip=1 and bubble_op=0.
- Forward select, computed per source at issue and registered into fa_mux_op/fb_mux_op:
  - EX slot valid, wen, rd==rs, rd!=0 -> EX_RESULT_SELECT (producer will sit in MEM).
  - Else MEM slot matches -> MEM_RESULT_SELECT (producer will be in WB).
  - Else, and for unused sources or bubbles, the register-operand (default) code.
  - Nearest producer wins. x0 is never forwarded.
- Load-use: EX slot is a valid load, wen, rd!=0, and rd matches a used source -> stall_op=1 and bubble_op=1 for exactly one cycle (combinational in that cycle). The next cycle the load is in MEM, so the consumer issues with MEM_RESULT_SELECT.
- FSM states:
  - RUN: ex_flush_en_ip=1 -> flush_op=1 and bubble_op=1 combinationally; counter loads FLUSH_DEPTH-1; go to FLUSH if the counter is >0. Otherwise a load-use hazard -> LD_STALL (the hazard outputs apply this cycle).
  - LD_STALL: a one-cycle marker used for counting; returns to RUN. A load-use hazard re-detected here is impossible (the EX slot is a bubble).
  - FLUSH: flush_op=1, bubble_op=1, stall_op=0; counter decrements; go to RUN when it reaches 0. ex_flush_en_ip=1 here reloads the counter to FLUSH_DEPTH-1.
- Priority: flush overrides load-use. stall_op=0 whenever flush_op=1.
- Latency: mux codes are valid in the cycle the instruction occupies EX (1 clock after issue).
- Reset (asynchronous, reset==0):
  - All slots invalid; state RUN; counter 0.
  - fa_mux_op and fb_mux_op at the default code; stall_op, bubble_op and flush_op at 0.
  - Reset mid-flush or mid-stall aborts immediately.
  - Outputs are defined (0/default) during reset, not X.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - Adds outputs perf_stall_cnt_op [CNT_W] (increments each cycle stall_op=1) and perf_flush_cnt_op [CNT_W] (increments once per accepted redirect, including reloads).
  - Counters saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent. Function is otherwise identical.

Test Plan:
- ADD x5 issued, then ADD x6,x5,x1 next cycle -> on the consumer's EX cycle fa_mux_op=EX_RESULT_SELECT, fb_mux_op=default, no stall.
- Producer x7, one independent instruction, then consumer rs2=x7 -> fb_mux_op=MEM_RESULT_SELECT. x7 writers at both distances -> EX_RESULT_SELECT.
- LW x8, then ADD x9,x8,x8 -> stall_op=1 and bubble_op=1 for exactly 1 cycle; the consumer then issues with fa_mux_op=fb_mux_op=MEM_RESULT_SELECT.
- ex_flush_en_ip pulsed 1 cycle with FLUSH_DEPTH=2 -> flush_op=1 and bubble_op=1 for 2 consecutive cycles; the EX slot stays invalid 2 cycles; no forwarding from squashed instructions.
- Load-use hazard coincident with ex_flush_en_ip -> stall_op=0, flush_op=1. Writer to x0 followed by reader of x0 -> default select.
- reset driven low mid-FLUSH (counter=1) -> all outputs 0/default asynchronously; after release, the first issued instruction shows no forwarding.

Source files
------------

// File: rtl/ex_hazard_controller.sv
// Execute-stage hazard unit: registered operand-forward selects, load-use stall and multi-cycle redirect flush.
// Define HAZ_PERF_CNT_EN to add saturating stall/flush performance counters.
module ex_hazard_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid_ip,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_ip,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_ip,
  input  logic                  id_rs1_used_ip,
  input  logic                  id_rs2_used_ip,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_ip,
  input  logic                  id_rd_wen_ip,
  input  logic                  id_is_load_ip,
  input  logic                  ex_flush_en_ip,
  output logic [1:0]            fa_mux_op,
  output logic [1:0]            fb_mux_op,
  output logic                  stall_op,
  output logic                  bubble_op,
  output logic                  flush_op
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cnt_op,
  output logic [CNT_W-1:0]      perf_flush_cnt_op
`endif
);

  // forward_mux_code encoding
  localparam logic [1:0] FWD_REG_OPERAND       = 2'b00;
  localparam logic [1:0] FWD_EX_RESULT_SELECT  = 2'b01;
  localparam logic [1:0] FWD_MEM_RESULT_SELECT = 2'b10;

  localparam logic [2:0]            FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO     = {REG_ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [2:0]            cnt_r, cnt_nxt_s;

  // A producer that has reached WB is already visible through the register file,
  // so only the EX and MEM occupants can supply a forwarded operand.
  logic                  ex_valid_r, ex_wen_r, ex_load_r;
  logic [REG_ADDR_W-1:0] ex_rd_r;
  logic                  mem_valid_r, mem_wen_r;
  logic [REG_ADDR_W-1:0] mem_rd_r;

  logic                  load_use_s, issue_s;
  logic                  stall_s, bubble_s, flush_s;
  logic [1:0]            fa_sel_s, fb_sel_s;

  // Nearest producer wins; x0 and unused sources always read the register operand.
  function automatic logic [1:0] fwd_select(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  exv,
    input logic                  exw,
    input logic [REG_ADDR_W-1:0] exrd,
    input logic                  memv,
    input logic                  memw,
    input logic [REG_ADDR_W-1:0] memrd
  );
    logic [1:0] sel;
    if (!used || rs == REG_ZERO) begin
      sel = FWD_REG_OPERAND;
    end else if (exv && exw && exrd == rs) begin
      sel = FWD_EX_RESULT_SELECT;
    end else if (memv && memw && memrd == rs) begin
      sel = FWD_MEM_RESULT_SELECT;
    end else begin
      sel = FWD_REG_OPERAND;
    end
    return sel;
  endfunction

  // Load in EX feeding a used source of the Decode instruction
  always_comb begin
    load_use_s = 1'b0;
    if (id_valid_ip && ex_valid_r && ex_load_r && ex_wen_r && ex_rd_r != REG_ZERO) begin
      load_use_s = (id_rs1_used_ip && id_rs1_addr_ip == ex_rd_r) ||
                   (id_rs2_used_ip && id_rs2_addr_ip == ex_rd_r);
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next-state, flush counter and front-end control
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    bubble_s    = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      ST_RUN, ST_LD_STALL: begin
        if (ex_flush_en_ip) begin
          flush_s     = 1'b1;
          bubble_s    = 1'b1;
          cnt_nxt_s   = FLUSH_RELOAD;
          state_nxt_s = (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end else if (load_use_s) begin
          stall_s     = 1'b1;
          bubble_s    = 1'b1;
          state_nxt_s = ST_LD_STALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_s  = 1'b1;
        bubble_s = 1'b1;
        if (ex_flush_en_ip) begin
          cnt_nxt_s   = FLUSH_RELOAD;
          state_nxt_s = (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end else if (cnt_r <= 3'd1) begin
          cnt_nxt_s   = 3'd0;
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s   = cnt_r - 3'd1;
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        cnt_nxt_s   = 3'd0;
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // Gated so the front-end controls are inactive while reset is held
  assign stall_op  = stall_s & reset;
  assign bubble_op = bubble_s & reset;
  assign flush_op  = flush_s & reset;

  assign issue_s  = id_valid_ip & ~bubble_s;
  assign fa_sel_s = fwd_select(id_rs1_used_ip, id_rs1_addr_ip, ex_valid_r, ex_wen_r, ex_rd_r,
                               mem_valid_r, mem_wen_r, mem_rd_r);
  assign fb_sel_s = fwd_select(id_rs2_used_ip, id_rs2_addr_ip, ex_valid_r, ex_wen_r, ex_rd_r,
                               mem_valid_r, mem_wen_r, mem_rd_r);

  // FSM state and flush counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Pipeline slot shift and registered forward selects
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid_r  <= 1'b0;
      ex_wen_r    <= 1'b0;
      ex_load_r   <= 1'b0;
      ex_rd_r     <= REG_ZERO;
      mem_valid_r <= 1'b0;
      mem_wen_r   <= 1'b0;
      mem_rd_r    <= REG_ZERO;
      fa_mux_op   <= FWD_REG_OPERAND;
      fb_mux_op   <= FWD_REG_OPERAND;
    end else begin
      ex_valid_r  <= issue_s;
      ex_wen_r    <= issue_s & id_rd_wen_ip;
      ex_load_r   <= issue_s & id_is_load_ip;
      ex_rd_r     <= issue_s ? id_rd_addr_ip : REG_ZERO;
      mem_valid_r <= ex_valid_r;
      mem_wen_r   <= ex_wen_r;
      mem_rd_r    <= ex_rd_r;
      fa_mux_op   <= issue_s ? fa_sel_s : FWD_REG_OPERAND;
      fb_mux_op   <= issue_s ? fb_sel_s : FWD_REG_OPERAND;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating stall-cycle and accepted-redirect counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt_op <= {CNT_W{1'b0}};
      perf_flush_cnt_op <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && perf_stall_cnt_op != CNT_MAX) begin
        perf_stall_cnt_op <= perf_stall_cnt_op + CNT_ONE;
      end
      if (ex_flush_en_ip && perf_flush_cnt_op != CNT_MAX) begin
        perf_flush_cnt_op <= perf_flush_cnt_op + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Self-checking bench for ex_hazard_controller: vector table with a select scoreboard plus reset/flush sequences.
module tb_ex_hazard_controller;

  localparam logic [1:0] R = 2'd0;  // register operand
  localparam logic [1:0] E = 2'd1;  // EX result select
  localparam logic [1:0] M = 2'd2;  // MEM result select
  localparam int NV = 30;

  logic       clock, reset;
  logic       id_valid_ip, id_rs1_used_ip, id_rs2_used_ip, id_rd_wen_ip, id_is_load_ip, ex_flush_en_ip;
  logic [4:0] id_rs1_addr_ip, id_rs2_addr_ip, id_rd_addr_ip;
  logic [1:0] fa_mux_op, fb_mux_op;
  logic       stall_op, bubble_op, flush_op;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_op, perf_flush_cnt_op;
`endif

  ex_hazard_controller #(.REG_ADDR_W(5), .FLUSH_DEPTH(2), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .id_valid_ip(id_valid_ip), .id_rs1_addr_ip(id_rs1_addr_ip), .id_rs2_addr_ip(id_rs2_addr_ip),
    .id_rs1_used_ip(id_rs1_used_ip), .id_rs2_used_ip(id_rs2_used_ip), .id_rd_addr_ip(id_rd_addr_ip),
    .id_rd_wen_ip(id_rd_wen_ip), .id_is_load_ip(id_is_load_ip), .ex_flush_en_ip(ex_flush_en_ip),
    .fa_mux_op(fa_mux_op), .fb_mux_op(fb_mux_op),
    .stall_op(stall_op), .bubble_op(bubble_op), .flush_op(flush_op)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cnt_op(perf_stall_cnt_op), .perf_flush_cnt_op(perf_flush_cnt_op)
`endif
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       ld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       fl;
    logic       es;
    logic       eb;
    logic       ef;
    logic [1:0] efa;
    logic [1:0] efb;
  } vec_t;

  vec_t       vecs [0:NV-1];
  logic [3:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic w, input logic ld,
                              input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                              input logic fl, input logic es, input logic eb, input logic ef,
                              input logic [1:0] efa, input logic [1:0] efb);
    vec_t t;
    t = '{valid: v, rd: rd, wen: w, ld: ld, rs1: rs1, u1: u1, rs2: rs2, u2: u2, fl: fl,
          es: es, eb: eb, ef: ef, efa: efa, efb: efb};
    return t;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid_ip    = v.valid;
    id_rd_addr_ip  = v.rd;
    id_rd_wen_ip   = v.wen;
    id_is_load_ip  = v.ld;
    id_rs1_addr_ip = v.rs1;
    id_rs1_used_ip = v.u1;
    id_rs2_addr_ip = v.rs2;
    id_rs2_used_ip = v.u2;
    ex_flush_en_ip = v.fl;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0] e;
    @(negedge clock);
    drive(v);
    #2;
    check($sformatf("stall[%0d]", idx), {7'd0, stall_op}, {7'd0, v.es});
    check($sformatf("bubble[%0d]", idx), {7'd0, bubble_op}, {7'd0, v.eb});
    check($sformatf("flush[%0d]", idx), {7'd0, flush_op}, {7'd0, v.ef});
    exp_q.push_back({v.efa, v.efb});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check($sformatf("fa[%0d]", idx), {6'd0, fa_mux_op}, {6'd0, e[3:2]});
    check($sformatf("fb[%0d]", idx), {6'd0, fb_mux_op}, {6'd0, e[1:0]});
  endtask

  initial begin
    //            v  rd  w  ld rs1 u1 rs2 u2 fl es eb ef efa efb
    vecs[0]  = mk(1, 5,  1, 0, 1,  1, 2,  1, 0, 0, 0, 0, R, R);
    vecs[1]  = mk(1, 6,  1, 0, 5,  1, 1,  1, 0, 0, 0, 0, E, R);  // back-to-back dependency
    vecs[2]  = mk(1, 7,  1, 0, 3,  1, 4,  1, 0, 0, 0, 0, R, R);
    vecs[3]  = mk(1, 10, 1, 0, 11, 1, 12, 1, 0, 0, 0, 0, R, R);
    vecs[4]  = mk(1, 13, 1, 0, 1,  1, 7,  1, 0, 0, 0, 0, R, M);  // producer two ahead
    vecs[5]  = mk(1, 7,  1, 0, 1,  1, 2,  1, 0, 0, 0, 0, R, R);
    vecs[6]  = mk(1, 7,  1, 0, 2,  1, 3,  1, 0, 0, 0, 0, R, R);
    vecs[7]  = mk(1, 14, 1, 0, 7,  1, 7,  1, 0, 0, 0, 0, E, E);  // x7 in EX and MEM: nearest wins
    vecs[8]  = mk(1, 8,  1, 1, 1,  1, 0,  0, 0, 0, 0, 0, R, R);  // LW x8
    vecs[9]  = mk(1, 9,  1, 0, 8,  1, 8,  1, 0, 1, 1, 0, R, R);  // load-use stall
    vecs[10] = mk(1, 9,  1, 0, 8,  1, 8,  1, 0, 0, 0, 0, M, M);  // reissue after stall
    vecs[11] = mk(1, 0,  1, 0, 1,  1, 2,  1, 0, 0, 0, 0, R, R);  // writes x0
    vecs[12] = mk(1, 15, 1, 0, 0,  1, 9,  1, 0, 0, 0, 0, R, M);  // reads x0
    vecs[13] = mk(1, 16, 1, 0, 15, 1, 15, 1, 1, 0, 1, 1, R, R);  // redirect
    vecs[14] = mk(1, 17, 1, 0, 15, 1, 1,  1, 0, 0, 1, 1, R, R);  // second flush cycle
    vecs[15] = mk(1, 18, 1, 0, 16, 1, 15, 1, 0, 0, 0, 0, R, R);  // no forward from squashed
    vecs[16] = mk(1, 20, 1, 1, 1,  1, 0,  0, 0, 0, 0, 0, R, R);  // LW x20
    vecs[17] = mk(1, 21, 1, 0, 20, 1, 0,  1, 1, 0, 1, 1, R, R);  // load-use with redirect
    vecs[18] = mk(1, 21, 1, 0, 20, 1, 0,  1, 0, 0, 1, 1, R, R);
    vecs[19] = mk(1, 22, 1, 0, 20, 1, 20, 1, 0, 0, 0, 0, R, R);
    vecs[20] = mk(1, 23, 1, 0, 22, 0, 22, 1, 0, 0, 0, 0, R, E);  // unused rs1
    vecs[21] = mk(1, 24, 0, 0, 23, 1, 1,  1, 0, 0, 0, 0, E, R);  // non-writing producer next
    vecs[22] = mk(1, 25, 1, 0, 24, 1, 24, 1, 0, 0, 0, 0, R, R);
    vecs[23] = mk(1, 26, 1, 0, 1,  1, 2,  1, 1, 0, 1, 1, R, R);  // redirect
    vecs[24] = mk(0, 0,  0, 0, 0,  0, 0,  0, 1, 0, 1, 1, R, R);  // reload while flushing
    vecs[25] = mk(0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 1, 1, R, R);
    vecs[26] = mk(1, 27, 1, 0, 25, 1, 26, 1, 0, 0, 0, 0, R, R);
    vecs[27] = mk(1, 28, 1, 1, 1,  1, 0,  0, 0, 0, 0, 0, R, R);  // LW x28
    vecs[28] = mk(1, 29, 1, 0, 28, 0, 28, 0, 0, 0, 0, 0, R, R);  // load rd matches unused sources
    vecs[29] = mk(1, 30, 1, 0, 29, 1, 28, 1, 0, 0, 0, 0, E, M);

    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R, R));
    #12;
    check("rst_fa", {6'd0, fa_mux_op}, {6'd0, R});
    check("rst_fb", {6'd0, fb_mux_op}, {6'd0, R});
    check("rst_stall", {7'd0, stall_op}, 8'd0);
    check("rst_bubble", {7'd0, bubble_op}, 8'd0);
    ex_flush_en_ip = 1'b1;
    #1;
    check("rst_flush_gated", {7'd0, flush_op}, 8'd0);
    ex_flush_en_ip = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // Asynchronous reset with a forwarded select registered
    @(negedge clock);
    drive(mk(1, 5, 1, 0, 1, 1, 2, 1, 0, 0, 0, 0, R, R));
    @(negedge clock);
    drive(mk(1, 6, 1, 0, 5, 1, 5, 1, 0, 0, 0, 0, R, R));
    @(posedge clock);
    #1;
    check("pre_rst_fa", {6'd0, fa_mux_op}, {6'd0, E});
    @(negedge clock);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, R, R));
    #1 reset = 1'b0;
    #1;
    check("async_rst_fa", {6'd0, fa_mux_op}, {6'd0, R});
    check("async_rst_fb", {6'd0, fb_mux_op}, {6'd0, R});
    check("async_rst_flush", {7'd0, flush_op}, 8'd0);
    #1 reset = 1'b1;
    #1;
    check("redirect_after_rel", {7'd0, flush_op}, 8'd1);

    // Reset mid-flush with the counter at 1
    @(negedge clock);
    ex_flush_en_ip = 1'b0;
    #2;
    check("mid_flush", {7'd0, flush_op}, 8'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_flush", {7'd0, flush_op}, 8'd0);
    check("abort_bubble", {7'd0, bubble_op}, 8'd0);
    check("abort_stall", {7'd0, stall_op}, 8'd0);
    @(negedge clock);
    #1 reset = 1'b1;
    drive(mk(1, 6, 1, 0, 5, 1, 6, 1, 0, 0, 0, 0, R, R));
    #1;
    check("post_rst_flush", {7'd0, flush_op}, 8'd0);
    check("post_rst_bubble", {7'd0, bubble_op}, 8'd0);
    @(posedge clock);
    #1;
    check("post_rst_fa", {6'd0, fa_mux_op}, {6'd0, R});
    check("post_rst_fb", {6'd0, fb_mux_op}, {6'd0, R});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
